// File: rtl/mem_strobe_responder.sv
// Memory-side responder for the strobe/complete/ready protocol, backed by a register array with fixed latency.
// Optional MEM_RESP_ERR_EN adds an err output for dual-strobe and out-of-range requests.
module mem_strobe_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk_cpu,
  input  logic        rst_n,
  input  logic [27:0] addr,
  input  logic [1:0]  width,
  input  logic [63:0] data_in,
  output logic [63:0] data_out,
  input  logic        rstrobe,
  input  logic        wstrobe,
  output logic        transaction_complete,
`ifdef MEM_RESP_ERR_EN
  output logic        err,
`endif
  output logic        ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, next_state;

  logic [63:0]           mem [2**DEPTH_LOG2];
  logic [7:0]            count;
  logic [DEPTH_LOG2-1:0] req_line;
  logic [2:0]            req_off;
  logic [1:0]            req_width;
  logic [63:0]           req_data;
  logic                  req_write;
  logic                  accept;
  logic                  access;
  logic [2:0]            aligned_off;
  logic [7:0]            byte_en;
  logic [63:0]           size_mask;
  logic [63:0]           wdata_shifted;
  logic [63:0]           rdata;
  logic                  mem_we;

`ifdef MEM_RESP_ERR_EN
  logic req_dual;
  logic req_oor;
  logic addr_oor;
  assign addr_oor = |addr[27:DEPTH_LOG2+3];
`else
  logic unused_hi_addr;
  assign unused_hi_addr = |addr[27:DEPTH_LOG2+3];
`endif

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (rstrobe || wstrobe) begin
          accept     = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (count == 8'd0) begin
          access     = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Offset is forced to the natural alignment of the access so nothing ever straddles a line.
  always_comb begin
    aligned_off = addr[2:0];
    case (width)
      2'b00:   aligned_off = addr[2:0];
      2'b01:   aligned_off = {addr[2:1], 1'b0};
      2'b10:   aligned_off = {addr[2], 2'b00};
      default: aligned_off = 3'b000;
    endcase
  end

  always_comb begin
    byte_en   = 8'hFF;
    size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    case (req_width)
      2'b00: begin byte_en = 8'h01; size_mask = 64'h0000_0000_0000_00FF; end
      2'b01: begin byte_en = 8'h03; size_mask = 64'h0000_0000_0000_FFFF; end
      2'b10: begin byte_en = 8'h0F; size_mask = 64'h0000_0000_FFFF_FFFF; end
      default: begin byte_en = 8'hFF; size_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
    endcase
    byte_en = byte_en << req_off;
  end

  assign wdata_shifted = req_data << {req_off, 3'b000};

`ifdef MEM_RESP_ERR_EN
  assign rdata  = req_oor ? 64'd0 : ((mem[req_line] >> {req_off, 3'b000}) & size_mask);
  assign mem_we = access && req_write && !req_oor;
`else
  assign rdata  = (mem[req_line] >> {req_off, 3'b000}) & size_mask;
  assign mem_we = access && req_write;
`endif

  // Request fields are frozen at the accept edge; the counter runs only while BUSY.
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      count                <= 8'd0;
      req_line             <= '0;
      req_off              <= 3'd0;
      req_width            <= 2'd0;
      req_data             <= 64'd0;
      req_write            <= 1'b0;
      transaction_complete <= 1'b0;
      data_out             <= 64'd0;
    end else begin
      transaction_complete <= access;
      if (accept) begin
        count     <= 8'(LATENCY - 1);
        req_line  <= addr[DEPTH_LOG2+2:3];
        req_off   <= aligned_off;
        req_width <= width;
        req_data  <= data_in;
        req_write <= wstrobe;
      end else if (state == BUSY && count != 8'd0) begin
        count <= count - 8'd1;
      end
      if (access && !req_write) data_out <= rdata;
    end
  end

`ifdef MEM_RESP_ERR_EN
  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      req_dual <= 1'b0;
      req_oor  <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        req_dual <= rstrobe && wstrobe;
        req_oor  <= addr_oor;
      end
      err <= access && (req_dual || req_oor);
    end
  end
`endif

  always_ff @(posedge clk_cpu) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++) begin
        if (byte_en[k]) mem[req_line][8*k +: 8] <= wdata_shifted[8*k +: 8];
      end
    end
  end

endmodule
